// File: rtl/user_output_device.sv
// Avalon-MM LED output device: VALUE/MASK/PERIOD/BRIGHT registers driving
// registered LED pins with blink phase and global PWM dimming.
module user_output_device #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned PRESCALE_DIV = 50000,
    parameter int unsigned PWM_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          avl_address,
    input  logic                avl_write,
    input  logic [31:0]         avl_writedata,
    input  logic                avl_read,
    output logic [31:0]         avl_readdata,
    output logic [NUM_LEDS-1:0] leds,
    output logic                blink_phase
);

    localparam int unsigned PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    typedef enum logic [1:0] {
        ADDR_VALUE  = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_BRIGHT = 2'd3
    } addr_e;

    logic [NUM_LEDS-1:0] r_value;
    logic [NUM_LEDS-1:0] r_mask;
    logic [15:0]         r_period;
    logic [PWM_W-1:0]    r_bright;
    logic [PRE_W-1:0]    r_pre;
    logic [15:0]         r_blink_cnt;
    logic                r_phase;
    logic [PWM_W-1:0]    r_pwm;
    logic [NUM_LEDS-1:0] r_leds;
    logic [31:0]         r_readdata;

    addr_e               w_addr;
    logic                w_tick;
    logic                w_pwm_on;
    logic                w_wr_period;
    logic [NUM_LEDS-1:0] w_next_led;
    logic [31:0]         w_rd_mux;
    logic                w_unused;

    assign w_addr      = addr_e'(avl_address);
    assign w_tick      = (r_pre == PRE_W'(PRESCALE_DIV - 1));
    assign w_pwm_on    = (r_bright == '1) | (r_pwm < r_bright);
    assign w_wr_period = avl_write && (w_addr == ADDR_PERIOD);
    assign w_next_led  = r_value & {NUM_LEDS{w_pwm_on}} & (~r_mask | {NUM_LEDS{r_phase}});
    // Write data bits above each register's width are intentionally dropped.
    assign w_unused    = ^avl_writedata;

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            ADDR_VALUE:  w_rd_mux[NUM_LEDS-1:0] = r_value;
            ADDR_MASK:   w_rd_mux[NUM_LEDS-1:0] = r_mask;
            ADDR_PERIOD: w_rd_mux[15:0]         = r_period;
            ADDR_BRIGHT: w_rd_mux[PWM_W-1:0]    = r_bright;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value     <= '0;
            r_mask      <= '0;
            r_period    <= '0;
            r_bright    <= '1;
            r_pre       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_pwm       <= '0;
            r_leds      <= '0;
            r_readdata  <= '0;
        end else begin
            // Read mux samples pre-edge registers, so a same-cycle write returns old data.
            if (avl_read) r_readdata <= w_rd_mux;
            if (avl_write) begin
                case (w_addr)
                    ADDR_VALUE:  r_value  <= avl_writedata[NUM_LEDS-1:0];
                    ADDR_MASK:   r_mask   <= avl_writedata[NUM_LEDS-1:0];
                    ADDR_PERIOD: r_period <= avl_writedata[15:0];
                    ADDR_BRIGHT: r_bright <= avl_writedata[PWM_W-1:0];
                    default: ;
                endcase
            end
            r_pwm  <= r_pwm + PWM_W'(1);
            r_leds <= w_next_led;
            if (w_wr_period) begin
                r_pre       <= '0;
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
                if (r_period == 16'd0) begin
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b1;
                end else if (w_tick) begin
                    if (r_blink_cnt == r_period - 16'd1) begin
                        r_blink_cnt <= '0;
                        r_phase     <= ~r_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign avl_readdata = r_readdata;
    assign leds         = r_leds;
    assign blink_phase  = r_phase;

endmodule

// File: tb/tb_user_output_device.sv
// Self-checking bench for user_output_device: register table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_user_output_device;

    localparam int unsigned NL  = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 4;
    localparam int unsigned PWM_MOD = 1 << PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    avl_address = '0;
    logic          avl_write = 1'b0;
    logic [31:0]   avl_writedata = '0;
    logic          avl_read = 1'b0;
    logic [31:0]   avl_readdata;
    logic [NL-1:0] leds;
    logic          blink_phase;

    user_output_device #(
        .NUM_LEDS(NL),
        .PRESCALE_DIV(DIV),
        .PWM_W(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avl_address(avl_address),
        .avl_write(avl_write),
        .avl_writedata(avl_writedata),
        .avl_read(avl_read),
        .avl_readdata(avl_readdata),
        .leds(leds),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: blink phase is derived from elapsed edges since the last
    // PERIOD write (or reset), PWM from elapsed edges since reset.
    logic [NL-1:0] m_value, m_mask, exp_leds;
    logic [15:0]   m_period;
    logic [PW-1:0] m_bright;
    logic [31:0]   exp_rd;
    logic          exp_phase;
    int unsigned   m_cyc, m_origin;
    bit            chk_en = 0;

    function automatic logic phase_at(input int unsigned c);
        int unsigned ticks;
        if (m_period == 0) return 1'b1;
        ticks = (c - m_origin) / DIV;
        return ((ticks / m_period) % 2) == 0;
    endfunction

    function automatic logic [31:0] reg_of(input logic [1:0] a);
        case (a)
            2'd0: return {24'b0, m_value};
            2'd1: return {24'b0, m_mask};
            2'd2: return {16'b0, m_period};
            default: return {28'b0, m_bright};
        endcase
    endfunction

    always @(posedge clk) begin
        logic p, pw;
        if (reset) begin
            m_value = '0; m_mask = '0; m_period = '0; m_bright = '1;
            m_cyc = 0; m_origin = 0;
            exp_leds = '0; exp_rd = '0; exp_phase = 1'b1;
        end else begin
            p  = phase_at(m_cyc);
            pw = (m_bright == 4'hF) || ((m_cyc % PWM_MOD) < m_bright);
            exp_leds = m_value & {NL{pw}} & (~m_mask | {NL{p}});
            if (avl_read) exp_rd = reg_of(avl_address);
            m_cyc++;
            if (avl_write) begin
                case (avl_address)
                    2'd0: m_value  = avl_writedata[NL-1:0];
                    2'd1: m_mask   = avl_writedata[NL-1:0];
                    2'd2: begin m_period = avl_writedata[15:0]; m_origin = m_cyc; end
                    default: m_bright = avl_writedata[PW-1:0];
                endcase
            end
            exp_phase = phase_at(m_cyc);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_leds", {24'b0, leds}, {24'b0, exp_leds});
            check("model_phase", {31'b0, blink_phase}, {31'b0, exp_phase});
            check("model_readdata", avl_readdata, exp_rd);
        end
    end

    // Applies one cycle of stimulus; returns at the negedge after the edge.
    task automatic drive(input logic rst, input logic [1:0] a, input logic wr,
                         input logic [31:0] wd, input logic rd);
        reset = rst; avl_address = a; avl_write = wr; avl_writedata = wd; avl_read = rd;
        @(negedge clk);
        reset = 1'b0; avl_write = 1'b0; avl_read = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(1'b0, a, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(1'b0, a, 1'b0, 32'h0, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cnt;
        logic [7:0] prev;

        vecs[0] = '{2'd0, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[1] = '{2'd1, 32'h1234_5603, 32'h0000_0003};
        vecs[2] = '{2'd2, 32'hABCD_0007, 32'h0000_0007};
        vecs[3] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0009};
        vecs[4] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{2'd3, 32'h0000_001F, 32'h0000_000F};
        vecs[6] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{2'd1, 32'h8000_0000, 32'h0000_0000};

        @(negedge clk);
        drive(1'b1, 2'd3, 1'b1, 32'h0, 1'b1);
        drive(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
        chk_en = 1;

        // Reset values
        check("rst_leds", {24'b0, leds}, 32'h0);
        check("rst_phase", {31'b0, blink_phase}, 32'h1);
        check("rst_readdata", avl_readdata, 32'h0);
        rd(2'd0); check("rst_value", avl_readdata, 32'h0);
        rd(2'd1); check("rst_mask", avl_readdata, 32'h0);
        rd(2'd2); check("rst_period", avl_readdata, 32'h0);
        rd(2'd3); check("rst_bright", avl_readdata, 32'hF);

        // Register table: write then read back with upper bits dropped
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr);
            check($sformatf("table_%0d", i), avl_readdata, vecs[i].exp_rd);
        end

        // VALUE=0xA5 visible one cycle after the write edge, then steady
        wr(2'd0, 32'hA5);
        check("a5_not_yet", {24'b0, leds}, 32'h0);
        idle();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (leds == 8'hA5) cnt++;
            idle();
        end
        check("a5_steady", cnt, 12);

        // Blink: PERIOD=2 gives 8-cycle half-periods on masked LEDs
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'h0F);
        wr(2'd2, 32'h2);
        check("blink_start_phase", {31'b0, blink_phase}, 32'h1);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            if (blink_phase == 1'b1 && leds == 8'hFF) cnt++;
        end
        check("blink_on_half", cnt, 7);
        idle();
        check("blink_phase_off", {31'b0, blink_phase}, 32'h0);
        idle();
        check("blink_leds_off", {24'b0, leds}, 32'hF0);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            if (blink_phase == 1'b0) cnt++;
        end
        check("blink_off_half", cnt, 6);
        check("blink_phase_on_again", {31'b0, blink_phase}, 32'h1);

        // PWM duty
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h4);
        idle(); idle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (leds[0]) cnt++;
            idle();
        end
        check("pwm_duty_4", cnt, 4);
        wr(2'd3, 32'h0);
        idle(); idle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (leds[0]) cnt++;
            idle();
        end
        check("pwm_duty_0", cnt, 0);
        wr(2'd3, 32'hF);

        // PERIOD write during off phase restarts the blink
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h1);
        cnt = 0;
        while (blink_phase !== 1'b0 && cnt < 20) begin
            idle();
            cnt++;
        end
        check("wait_off_phase", {31'b0, blink_phase}, 32'h0);
        wr(2'd2, 32'h3);
        check("period_wr_phase", {31'b0, blink_phase}, 32'h1);
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            idle();
            if (blink_phase == 1'b1) cnt++;
        end
        check("period3_hold", cnt, 11);
        idle();
        check("period3_toggle", {31'b0, blink_phase}, 32'h0);

        // Same-cycle read and write return the old value
        drive(1'b0, 2'd0, 1'b1, 32'h3C, 1'b1);
        check("rw_old", avl_readdata, 32'hFF);
        idle();
        check("rd_hold", avl_readdata, 32'hFF);
        rd(2'd0);
        check("rw_new", avl_readdata, 32'h3C);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd2) d = {d[31:16], 16'($urandom_range(0, 4))};
            if ($urandom_range(0, 99) < 3)
                drive(1'b1, a, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 99) < (a == 2'd2 ? 4 : 20))
                drive(1'b0, a, 1'b1, d, 1'($urandom_range(0, 1)));
            else
                drive(1'b0, a, 1'b0, d, 1'($urandom_range(0, 3) == 0));
        end

        // Reset while blinking with nonzero readdata; strobes in reset ignored
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'h0F);
        wr(2'd2, 32'h1);
        rd(2'd0);
        for (int i = 0; i < 6; i++) idle();
        prev = avl_readdata[7:0];
        check("pre_reset_rd", {24'b0, prev}, 32'hFF);
        drive(1'b1, 2'd3, 1'b1, 32'h2, 1'b1);
        check("mid_reset_leds", {24'b0, leds}, 32'h0);
        check("mid_reset_rd", avl_readdata, 32'h0);
        check("mid_reset_phase", {31'b0, blink_phase}, 32'h1);
        rd(2'd3);
        check("post_reset_bright", avl_readdata, 32'hF);
        idle();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
